// File: rtl/spi_mem_pkg.sv
// Shared state encoding, frame constants and default widths for the SPI-slave memory sequencer.
package spi_mem_pkg;

    localparam int   DEF_ADDR_W = 7;
    localparam int   DEF_DATA_W = 8;
    localparam logic RW_READ    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        READ_WAIT,
        READ_LOAD,
        READ_SHIFT,
        WRITE_GET,
        WRITE_PULSE,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with clear, parallel load, serial-in shift-left and MSB tap.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q,
    output logic         o_msb
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], i_sin};
        end
    end

    assign o_q   = r_q;
    assign o_msb = r_q[W-1];

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI-slave sequencer: command frame -> one memory write or one serialised read.
// Define SPI_MEM_BURST_EN to continue with auto-incremented addresses while cs_n stays low.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk_rise,
    input  logic              sclk_fall,
    input  logic              mosi,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              miso,
    output logic              miso_oe,
    output logic              busy
);

    // rx only needs the bits that precede the final (live) mosi bit of a field
    localparam int RX_W  = max_int(ADDR_W, DATA_W - 1);
    localparam int CNT_W = $clog2(max_int(ADDR_W + 1, DATA_W) + 1);

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_din, w_din_next;
    logic              r_oe, w_oe_next;
    logic              w_rx_clr, w_rx_shift, w_tx_load, w_tx_shift;
    logic [RX_W-1:0]   w_rx_q;
    logic              w_rx_msb;
    logic [DATA_W-1:0] w_tx_q;
    logic              w_tx_msb;
    logic              w_unused;

    spi_shift_reg #(.W(RX_W)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_rx_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_shift    (w_rx_shift),
        .i_sin      (mosi),
        .o_q        (w_rx_q),
        .o_msb      (w_rx_msb)
    );

    spi_shift_reg #(.W(DATA_W)) u_tx (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (1'b0),
        .i_load     (w_tx_load),
        .i_load_val (mem_dout),
        .i_shift    (w_tx_shift),
        .i_sin      (1'b0),
        .o_q        (w_tx_q),
        .o_msb      (w_tx_msb)
    );

    assign w_unused = ^{w_rx_msb, w_tx_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_din   <= w_din_next;
            r_oe    <= w_oe_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_din_next   = r_din;
        w_oe_next    = r_oe;
        w_rx_clr     = 1'b0;
        w_rx_shift   = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_shift   = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                w_rx_clr   = 1'b1;
                w_oe_next  = 1'b0;
                if (!cs_n) w_state_next = GET_CMD;
            end
            GET_CMD: begin
                if (sclk_rise) begin
                    w_rx_shift = 1'b1;
                    w_cnt_next = r_cnt + CNT_W'(1);
                    // on the R/W rise, mosi itself is the direction bit
                    if (r_cnt == CNT_W'(ADDR_W)) begin
                        w_addr_next  = w_rx_q[ADDR_W-1:0];
                        w_cnt_next   = '0;
                        w_state_next = (mosi == RW_READ) ? READ_WAIT : WRITE_GET;
                    end
                end
            end
            READ_WAIT: w_state_next = READ_LOAD;
            READ_LOAD: begin
                w_tx_load    = 1'b1;
                w_oe_next    = 1'b1;
                w_state_next = READ_SHIFT;
            end
            READ_SHIFT: begin
                // the fall right after the R/W rise must keep the freshly loaded MSB
                if (sclk_fall && (r_cnt != '0)) w_tx_shift = 1'b1;
                if (sclk_rise) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_cnt_next = '0;
`ifdef SPI_MEM_BURST_EN
                        w_addr_next  = r_addr + ADDR_W'(1);
                        w_state_next = READ_WAIT;
`else
                        w_oe_next    = 1'b0;
                        w_state_next = DONE;
`endif
                    end
                end
            end
            WRITE_GET: begin
                if (sclk_rise) begin
                    w_rx_shift = 1'b1;
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_cnt_next   = '0;
                        w_din_next   = {w_rx_q[DATA_W-2:0], mosi};
                        w_state_next = WRITE_PULSE;
                    end
                end
            end
            WRITE_PULSE: begin
                if (cs_n) begin
                    w_state_next = IDLE;
                end else begin
`ifdef SPI_MEM_BURST_EN
                    w_addr_next  = r_addr + ADDR_W'(1);
                    w_state_next = WRITE_GET;
`else
                    w_state_next = DONE;
`endif
                end
            end
            DONE: w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase

        // deselect aborts everything except a write that is already committing
        if (cs_n && (r_state != WRITE_PULSE)) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_addr_next  = r_addr;
            w_din_next   = r_din;
            w_oe_next    = 1'b0;
            w_rx_shift   = 1'b0;
            w_tx_load    = 1'b0;
            w_tx_shift   = 1'b0;
        end
    end

    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign mem_we   = (r_state == WRITE_PULSE);
    assign miso_oe  = r_oe;
    assign miso     = r_oe & w_tx_msb;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: behavioural SPI master, memory model and frame-level reference.
module tb_spi_mem_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       mosi;
    logic [7:0] mem_dout = 8'h00;
    logic [6:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;
    logic       miso;
    logic       miso_oe;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] env_mem [128];
    logic [7:0] ref_mem [128];
    logic [6:0] log_addr [$];
    logic [7:0] log_data [$];
    int         oe_cycles = 0;

    spi_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi      (mosi),
        .mem_dout  (mem_dout),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // data memory with registered read, plus write/oe observation
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr] <= mem_din;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_din);
        end
        mem_dout <= env_mem[mem_addr];
        if (miso_oe) oe_cycles <= oe_cycles + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic s, output logic oe_f);
        mosi = b;
        tick();
        sclk_rise = 1'b1;
        s = miso;
        tick();
        sclk_rise = 1'b0;
        tick();
        tick();
        sclk_fall = 1'b1;
        oe_f = miso_oe;
        tick();
        sclk_fall = 1'b0;
        tick();
        tick();
    endtask

    // selects the slave and sends address + R/W; returns miso_oe seen at the fall after R/W
    task automatic send_cmd(input logic [6:0] addr, input logic rw, output logic oe_rw);
        logic s, f;
        cs_n = 1'b0;
        tick();
        tick();
        for (int i = 6; i >= 0; i--) spi_bit(addr[i], s, f);
        spi_bit(rw, s, oe_rw);
    endtask

    task automatic frame(input logic [6:0] addr, input logic rw, input int nbytes,
                         input logic [15:0] wdata, output logic [15:0] rdata,
                         output logic oe_rw, output logic oe_end, output logic busy_end);
        logic s, f;
        rdata = 16'h0000;
        send_cmd(addr, rw, oe_rw);
        for (int i = nbytes * 8 - 1; i >= 0; i--) begin
            spi_bit(rw ? 1'b0 : wdata[i], s, f);
            rdata = {rdata[14:0], s};
        end
        tick();
        oe_end   = miso_oe;
        busy_end = busy;
        cs_n = 1'b1;
        tick();
        tick();
        $display("frame %s addr=%02h bytes=%0d wdata=%04h rdata=%04h", rw ? "RD" : "WR",
                 addr, nbytes, wdata, rdata);
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0; mosi = 1'b0;
        tick();
        tick();
        checks++; if (mem_addr !== 7'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_din got=%h exp=00", mem_din); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", miso_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [15:0] rd;
        logic oe_rw, oe_end, busy_end;
        int n0, oe0;
        n0 = log_addr.size();
        oe0 = oe_cycles;
        frame(7'h15, 1'b0, 1, 16'h00A5, rd, oe_rw, oe_end, busy_end);
        ref_mem[7'h15] = 8'hA5;
        checks++; if (log_addr.size() != n0 + 1) begin errors++; $display("FAIL wr_count got=%0d exp=1", log_addr.size() - n0); end
        else begin
            checks++; if (log_addr[n0] !== 7'h15) begin errors++; $display("FAIL wr_addr got=%h exp=15", log_addr[n0]); end
            checks++; if (log_data[n0] !== 8'hA5) begin errors++; $display("FAIL wr_data got=%h exp=a5", log_data[n0]); end
        end
        checks++; if (oe_cycles != oe0) begin errors++; $display("FAIL wr_oe got=%0d cycles exp=0", oe_cycles - oe0); end
        checks++; if (busy_end !== 1'b1) begin errors++; $display("FAIL wr_busy_done got=%b exp=1", busy_end); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_read();
        logic [15:0] rd;
        logic oe_rw, oe_end, busy_end;
        int n0;
        frame(7'h15, 1'b0, 1, 16'h003C, rd, oe_rw, oe_end, busy_end);
        ref_mem[7'h15] = 8'h3C;
        n0 = log_addr.size();
        frame(7'h15, 1'b1, 1, 16'h0000, rd, oe_rw, oe_end, busy_end);
        checks++; if (rd[7:0] !== ref_mem[7'h15]) begin errors++; $display("FAIL rd_data got=%h exp=%h", rd[7:0], ref_mem[7'h15]); end
        checks++; if (oe_rw !== 1'b1) begin errors++; $display("FAIL rd_oe_before_fall got=%b exp=1", oe_rw); end
        checks++; if (log_addr.size() != n0) begin errors++; $display("FAIL rd_no_we got=%0d exp=0", log_addr.size() - n0); end
        checks++; if (busy_end !== 1'b1) begin errors++; $display("FAIL rd_busy got=%b exp=1", busy_end); end
`ifndef SPI_MEM_BURST_EN
        checks++; if (oe_end !== 1'b0) begin errors++; $display("FAIL rd_oe_done got=%b exp=0", oe_end); end
`endif
    endtask

    task automatic test_random();
        logic [6:0] pool [6];
        logic [15:0] rd;
        logic oe_rw, oe_end, busy_end;
        logic [7:0] d;
        logic [6:0] ad;
        logic rw;
        int n0;
        for (int i = 0; i < 6; i++) begin
            pool[i] = 7'($urandom_range(0, 127));
            d = 8'($urandom_range(0, 255));
            n0 = log_addr.size();
            frame(pool[i], 1'b0, 1, {8'h00, d}, rd, oe_rw, oe_end, busy_end);
            ref_mem[pool[i]] = d;
            checks++;
            if (log_addr.size() != n0 + 1 || log_addr[n0] !== pool[i] || log_data[n0] !== d) begin
                errors++; $display("FAIL rand_wr writes=%0d exp addr=%h data=%h", log_addr.size() - n0, pool[i], d);
            end
        end
        for (int i = 0; i < 14; i++) begin
            ad = pool[$urandom_range(0, 5)];
            rw = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            n0 = log_addr.size();
            frame(ad, rw, 1, {8'h00, d}, rd, oe_rw, oe_end, busy_end);
            if (rw) begin
                checks++; if (rd[7:0] !== ref_mem[ad]) begin errors++; $display("FAIL rand_rd addr=%h got=%h exp=%h", ad, rd[7:0], ref_mem[ad]); end
            end else begin
                ref_mem[ad] = d;
                checks++;
                if (log_addr.size() != n0 + 1 || log_addr[n0] !== ad || log_data[n0] !== d) begin
                    errors++; $display("FAIL rand_wr2 writes=%0d exp addr=%h data=%h", log_addr.size() - n0, ad, d);
                end
            end
        end
    endtask

    task automatic test_abort_write();
        logic s, f, oe_rw, oe_end, busy_end;
        logic [15:0] rd;
        int n0;
        n0 = log_addr.size();
        send_cmd(7'h15, 1'b0, oe_rw);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, s, f);
        cs_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tick();
        checks++; if (log_addr.size() != n0) begin errors++; $display("FAIL abort_we got=%0d exp=0", log_addr.size() - n0); end
        $display("frame WR addr=15 aborted after 4 data bits");
        frame(7'h15, 1'b1, 1, 16'h0000, rd, oe_rw, oe_end, busy_end);
        checks++; if (rd[7:0] !== ref_mem[7'h15]) begin errors++; $display("FAIL abort_readback got=%h exp=%h", rd[7:0], ref_mem[7'h15]); end
    endtask

    task automatic test_reset_mid_read();
        logic s, f, oe_rw, oe_end, busy_end;
        logic [15:0] rd;
        send_cmd(7'h15, 1'b1, oe_rw);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, s, f);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got=%b exp=0", miso_oe); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got=%b exp=0", miso); end
        checks++; if (mem_addr !== 7'h00) begin errors++; $display("FAIL rst_addr got=%h exp=00", mem_addr); end
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rst_din got=%h exp=00", mem_din); end
        cs_n = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        $display("frame RD addr=15 interrupted by reset");
        frame(7'h15, 1'b1, 1, 16'h0000, rd, oe_rw, oe_end, busy_end);
        checks++; if (rd[7:0] !== ref_mem[7'h15]) begin errors++; $display("FAIL rst_next_rd got=%h exp=%h", rd[7:0], ref_mem[7'h15]); end
    endtask

    task automatic test_cs_at_pulse();
        logic s, f, oe_rw;
        logic [7:0] d;
        int n0;
        d = 8'h6B;
        n0 = log_addr.size();
        send_cmd(7'h2A, 1'b0, oe_rw);
        for (int i = 7; i >= 1; i--) spi_bit(d[i], s, f);
        mosi = d[0];
        tick();
        sclk_rise = 1'b1;
        tick();
        sclk_rise = 1'b0;
        cs_n = 1'b1;
        tick();
        tick();
        ref_mem[7'h2A] = d;
        $display("frame WR addr=2a data=%h cs_n raised during write pulse", d);
        checks++; if (log_addr.size() != n0 + 1) begin errors++; $display("FAIL csp_count got=%0d exp=1", log_addr.size() - n0); end
        else begin
            checks++; if (log_addr[n0] !== 7'h2A || log_data[n0] !== d) begin errors++; $display("FAIL csp_write got=%h/%h exp=2a/%h", log_addr[n0], log_data[n0], d); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL csp_busy got=%b exp=0", busy); end
    endtask

    task automatic test_multi_byte();
        logic [15:0] rd;
        logic oe_rw, oe_end, busy_end;
        logic [7:0] exp_d [2];
        int n0, exp_n;
        exp_d[0] = 8'h11;
        exp_d[1] = 8'h22;
`ifdef SPI_MEM_BURST_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        n0 = log_addr.size();
        frame(7'h7F, 1'b0, 2, 16'h1122, rd, oe_rw, oe_end, busy_end);
        for (int k = 0; k < exp_n; k++) ref_mem[7'(7'h7F + k)] = exp_d[k];
        checks++; if (log_addr.size() != n0 + exp_n) begin errors++; $display("FAIL mb_count got=%0d exp=%0d", log_addr.size() - n0, exp_n); end
        else begin
            for (int k = 0; k < exp_n; k++) begin
                checks++;
                if (log_addr[n0 + k] !== 7'(7'h7F + k) || log_data[n0 + k] !== exp_d[k]) begin
                    errors++; $display("FAIL mb_write%0d got=%h/%h exp=%h/%h", k, log_addr[n0 + k], log_data[n0 + k], 7'(7'h7F + k), exp_d[k]);
                end
            end
        end
`ifdef SPI_MEM_BURST_EN
        frame(7'h7F, 1'b1, 2, 16'h0000, rd, oe_rw, oe_end, busy_end);
        checks++; if (rd !== {ref_mem[7'h7F], ref_mem[7'h00]}) begin errors++; $display("FAIL mb_read got=%h exp=%h%h", rd, ref_mem[7'h7F], ref_mem[7'h00]); end
`else
        frame(7'h7F, 1'b1, 1, 16'h0000, rd, oe_rw, oe_end, busy_end);
        checks++; if (rd[7:0] !== ref_mem[7'h7F]) begin errors++; $display("FAIL mb_read got=%h exp=%h", rd[7:0], ref_mem[7'h7F]); end
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_abort_write();
        test_reset_mid_read();
        test_cs_at_pulse();
        test_multi_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- SPI-slave transaction sequencer that shares the on-chip data memory with a serial master.
- Deserialises an address/command frame from MOSI, then either writes one data byte into memory or reads one byte and serialises it on MISO.
- Sits between the SCLK edge detector / CS synchroniser and the datamemory block.
- Drives the memory's address, dataIn and writeEnable ports, and consumes its 1-cycle registered dataOut.

Parameters:
- ADDR_W, 7: memory address width. The command frame is ADDR_W address bits plus 1 R/W bit.
- DATA_W, 8: memory data width and data-phase bit count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs_n  in  1  chip select, already synchronised to clk, active-low.
- sclk_rise  in  1  one-clk pulse per SCLK rising edge (sample MOSI).
- sclk_fall  in  1  one-clk pulse per SCLK falling edge (update MISO).
- mosi  in  1  synchronised serial data in.
- mem_dout  in  DATA_W  memory dataOut, valid 1 clk after mem_addr is presented.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable, one-clk pulse.
- miso  out  1  serial data out.
- miso_oe  out  1  MISO tristate enable, 1 only during the read data phase.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async): state IDLE; mem_addr, mem_din, mem_we, miso, miso_oe, busy all 0; bit counter and shift registers 0.
- Timing contract: consecutive sclk_rise/sclk_fall pulses are at least 3 clk apart.
- Frame format: MSB first, SPI mode 0.
  - Bits 1..ADDR_W are the address.
  - Bit ADDR_W+1 is R/W (1 = read, 0 = write).
  - Followed by DATA_W data bits.
- IDLE: go to GET_CMD when cs_n is 0; clear the bit counter.
- GET_CMD: each sclk_rise shifts mosi into the rx register and increments the counter. On the (ADDR_W+1)th rise:
  - mem_addr is latched from the rx address bits and the counter is cleared.
  - R/W=1 goes to READ_WAIT; R/W=0 goes to WRITE_GET.
- READ_WAIT: 1 clk while the memory registers dataOut; then go to READ_LOAD.
- READ_LOAD: load the tx register from mem_dout; miso_oe=1; miso = tx MSB; go to READ_SHIFT. Load completes 2 clk after the last command rise, i.e. before the following fall.
- READ_SHIFT:
  - sclk_fall shifts tx left only when the data-phase rise count is nonzero. The fall that follows the R/W bit is ignored.
  - sclk_rise increments the count. On the DATA_W-th rise, go to DONE and set miso_oe=0.
- WRITE_GET: sclk_rise shifts mosi in. On the DATA_W-th rise, mem_din is set to the rx byte and the state goes to WRITE_PULSE.
- WRITE_PULSE: mem_we=1 for exactly one clk; then go to DONE.
- DONE: ignore SCLK pulses; go to IDLE when cs_n is 1.
- cs_n=1 in any state except WRITE_PULSE: go to IDLE on the next clk and set miso_oe=0.
  - A partial byte is never written.
  - cs_n wins over a simultaneous sclk pulse.
- cs_n=1 during WRITE_PULSE: the write commits (byte complete), then the state goes to IDLE.
- mem_we is 0 in every state except WRITE_PULSE.
- mem_addr holds its value until the next command is latched.

Optional Feature:
- Macro SPI_MEM_BURST_EN.
- Defined: after a read or write byte completes with cs_n still 0, mem_addr increments modulo 2^ADDR_W, with wrap from all-ones to 0.
  - A read continues via READ_WAIT/READ_LOAD.
  - A write continues in WRITE_GET.
  - Same R/W direction; no new command frame.
- Undefined: exactly one data byte per frame; DONE until cs_n rises.

Decomposition:
- Package spi_mem_pkg holds:
  - State enum: IDLE, GET_CMD, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_PULSE, DONE.
  - Constant RW_READ=1.
  - Default widths.
- Sub-module spi_shift_reg: DATA_W-wide, with serial-in, parallel-load, shift-enable and MSB-out. Instantiate twice (rx, tx).

Test Plan:
- Write frame: addr 0x15, R/W=0, data 0xA5 → exactly one mem_we pulse with mem_addr=0x15 and mem_din=0xA5; miso_oe stays 0.
- Read frame: addr 0x15, R/W=1, memory returns 0x3C → miso_oe rises before the data-phase fall; master samples 0,0,1,1,1,1,0,0 on rises 9..16; then DONE.
- cs_n deasserted after 4 data bits of a write → no mem_we; IDLE within 1 clk; busy=0.
- reset asserted mid READ_SHIFT → all outputs 0 immediately, with no clk needed; the next frame after release behaves normally.
- cs_n rising in the same clk as WRITE_PULSE → the write commits once, then IDLE.
- With SPI_MEM_BURST_EN: write to addr 0x7F, data 0x11 then 0x22 → writes to 0x7F then 0x00 (wrap).
